// File: rtl/coax_biphase_rx_if.sv
// Line-side input and word-side outputs of the coax bi-phase receiver.
// The slave modport is the receiver itself; master is whatever drives the line and consumes words.
interface coax_biphase_rx_if;
    logic        serial_in;
    logic [11:0] rx_data;
    logic        rx_valid;
    logic        rx_toggle;
    logic        frame_active;
    logic        frame_end;
    logic        frame_err;

    modport master (
        output serial_in,
        input  rx_data, rx_valid, rx_toggle, frame_active, frame_end, frame_err
    );

    modport slave (
        input  serial_in,
        output rx_data, rx_valid, rx_toggle, frame_active, frame_end, frame_err
    );
endinterface

// File: rtl/coax_biphase_rx.sv
// IBM 3270 coax bi-phase receiver: recovers bit timing from line transitions,
// detects quiesce + code-violation start, decodes 12-bit words with parity check.
module coax_biphase_rx #(
    parameter int unsigned HALF_BIT     = 6,
    parameter int unsigned TOL          = 2,
    parameter int unsigned QUIESCE_BITS = 5
) (
    input  logic             sclk12,
    input  logic             rst,
    coax_biphase_rx_if.slave rx_if
);
    localparam int unsigned QMAX    = 2 * QUIESCE_BITS - 1;
    localparam int unsigned QW      = (QMAX > 1) ? $clog2(QMAX + 1) : 1;
    localparam int unsigned TIMEOUT = 2 * HALF_BIT + TOL + 1;

    typedef enum logic [2:0] {HUNT, VIOL_HI, VIOL_LO, SYNC, DATA, PARITY} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [5:0]    cnt_q, cnt_d, cnt_inc;
    logic [QW-1:0] qcount_q, qcount_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [9:0]    data_q, data_d;
    logic          first_word_q, first_word_d;
    logic [11:0]   rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_toggle_q, rx_toggle_d;
    logic          frame_active_q, frame_active_d;
    logic          frame_end_q, frame_end_d;
    logic          frame_err_q, frame_err_d;

    logic trans, rise, bit_val, bnd_win, mid_win, viol_win, timeout;

    function automatic logic in_win(input logic [5:0] v, input int unsigned center);
        return (32'(v) + TOL >= center) && (32'(v) <= center + TOL);
    endfunction

    always_ff @(posedge sclk12 or posedge rst) begin
        if (rst) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            prev_q         <= 1'b0;
            state_q        <= HUNT;
            cnt_q          <= '0;
            qcount_q       <= '0;
            bit_idx_q      <= '0;
            data_q         <= '0;
            first_word_q   <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_toggle_q    <= 1'b0;
            frame_active_q <= 1'b0;
            frame_end_q    <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sync1_q        <= rx_if.serial_in;
            sync2_q        <= sync1_q;
            prev_q         <= sync2_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            qcount_q       <= qcount_d;
            bit_idx_q      <= bit_idx_d;
            data_q         <= data_d;
            first_word_q   <= first_word_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_toggle_q    <= rx_toggle_d;
            frame_active_q <= frame_active_d;
            frame_end_q    <= frame_end_d;
            frame_err_q    <= frame_err_d;
        end
    end

    // cnt_inc is the number of cycles since the last reference transition,
    // counting the current one, so run lengths compare symmetrically against the windows.
    always_comb begin
        trans    = sync2_q ^ prev_q;
        rise     = sync2_q & ~prev_q;
        bit_val  = ~sync2_q;
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 6'd1;
        bnd_win  = in_win(cnt_inc, HALF_BIT);
        mid_win  = in_win(cnt_inc, 2 * HALF_BIT);
        viol_win = in_win(cnt_inc, 3 * HALF_BIT);
        timeout  = 32'(cnt_inc) >= TIMEOUT;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_inc;
        qcount_d       = qcount_q;
        bit_idx_d      = bit_idx_q;
        data_d         = data_q;
        first_word_d   = first_word_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_toggle_d    = rx_toggle_q;
        frame_active_d = frame_active_q;
        frame_end_d    = 1'b0;
        frame_err_d    = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (trans) begin
                    cnt_d = '0;
                    if (!bnd_win) begin
                        qcount_d = '0;
                    end else if (rise && 32'(qcount_q) >= QMAX) begin
                        state_d  = VIOL_HI;
                        qcount_d = '0;
                    end else if (32'(qcount_q) < QMAX) begin
                        qcount_d = qcount_q + 1'b1;
                    end
                end
            end
            VIOL_HI: begin
                if (trans) begin
                    cnt_d   = '0;
                    state_d = (viol_win && !sync2_q) ? VIOL_LO : HUNT;
                end
            end
            VIOL_LO: begin
                if (trans) begin
                    if (viol_win && rise) begin
                        state_d        = SYNC;
                        cnt_d          = 6'(HALF_BIT);
                        frame_active_d = 1'b1;
                        first_word_d   = 1'b1;
                    end else begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end
                end
            end
            SYNC, DATA, PARITY: begin
                if (trans && mid_win) begin
                    cnt_d = '0;
                    case (state_q)
                        SYNC: begin
                            if (bit_val) begin
                                state_d   = DATA;
                                bit_idx_d = 4'd9;
                            end else begin
                                state_d        = HUNT;
                                frame_end_d    = 1'b1;
                                frame_active_d = 1'b0;
                                qcount_d       = '0;
                            end
                        end
                        DATA: begin
                            data_d = {data_q[8:0], bit_val};
                            if (bit_idx_q == 4'd0) begin
                                state_d = PARITY;
                            end else begin
                                bit_idx_d = bit_idx_q - 4'd1;
                            end
                        end
                        default: begin
                            rx_data_d    = {bit_val ^ (^data_q), first_word_q, data_q};
                            rx_valid_d   = 1'b1;
                            rx_toggle_d  = ~rx_toggle_q;
                            first_word_d = 1'b0;
                            state_d      = SYNC;
                        end
                    endcase
                end else if ((trans && !bnd_win) || (!trans && timeout)) begin
                    if (trans) begin
                        cnt_d = '0;
                    end
                    state_d        = HUNT;
                    frame_err_d    = 1'b1;
                    frame_active_d = 1'b0;
                    qcount_d       = '0;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign rx_if.rx_data      = rx_data_q;
    assign rx_if.rx_valid     = rx_valid_q;
    assign rx_if.rx_toggle    = rx_toggle_q;
    assign rx_if.frame_active = frame_active_q;
    assign rx_if.frame_end    = frame_end_q;
    assign rx_if.frame_err    = frame_err_q;
endmodule

// File: tb/tb_coax_biphase_rx.sv
// Directed bench for coax_biphase_rx: line stimulus with hand-computed words pushed to a
// scoreboard queue; an independent monitor pops and compares on every rx_valid.
module tb_coax_biphase_rx;
    logic sclk12 = 1'b0;
    logic rst    = 1'b0;

    coax_biphase_rx_if bus ();

    coax_biphase_rx #(
        .HALF_BIT    (6),
        .TOL         (2),
        .QUIESCE_BITS(5)
    ) dut (
        .sclk12(sclk12),
        .rst   (rst),
        .rx_if (bus)
    );

    always #5 sclk12 = ~sclk12;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned valid_n     = 0;
    int unsigned end_n       = 0;
    int unsigned err_n       = 0;
    int unsigned err_cyc     = 0;
    int unsigned mid_cyc     = 0;
    int unsigned v0, e0, r0;
    logic        exp_toggle  = 1'b0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, 32'({bus.rx_data, bus.rx_valid, bus.rx_toggle,
                       bus.frame_active, bus.frame_end, bus.frame_err}), 0);
    endtask

    task automatic snap();
        v0 = valid_n;
        e0 = end_n;
        r0 = err_n;
    endtask

    task automatic chk_counts(input string tag, input int unsigned nv,
                              input int unsigned ne, input int unsigned nr);
        chk({tag, "_valids"}, valid_n - v0, nv);
        chk({tag, "_frame_ends"}, end_n - e0, ne);
        chk({tag, "_frame_errs"}, err_n - r0, nr);
    endtask

    task automatic hold(input logic v, input int n);
        bus.serial_in = v;
        repeat (n) @(negedge sclk12);
    endtask

    // first half is 6 cycles; d stretches/shrinks the second half, i.e. every mid-to-mid gap
    task automatic send_bit(input logic b, input int d);
        hold(b, 6);
        mid_cyc = cyc;
        hold(~b, 6 + d);
    endtask

    task automatic preamble(input int ones, input int d, input int vhi);
        hold(1'b0, 30);
        for (int i = 0; i < ones; i++) send_bit(1'b1, d);
        hold(1'b1, vhi);
        hold(1'b0, 18 + d);
    endtask

    task automatic send_word(input logic [9:0] w, input logic p, input logic [11:0] exp, input int d);
        exp_q.push_back(exp);
        send_bit(1'b1, d);
        for (int i = 9; i >= 0; i--) send_bit(w[i], d);
        send_bit(p, d);
    endtask

    task automatic tail(input int d);
        send_bit(1'b0, d);
        hold(1'b0, 30);
    endtask

    initial forever begin
        @(posedge sclk12);
        cyc++;
    end

    initial begin
        logic [11:0] e;
        forever begin
            @(negedge sclk12);
            if (!rst) begin
                if (bus.rx_valid || bus.frame_end || bus.frame_err)
                    chk("pulse_onehot",
                        32'($countones({bus.rx_valid, bus.frame_end, bus.frame_err})), 1);
                if (bus.frame_end) end_n++;
                if (bus.frame_err) begin
                    err_n++;
                    err_cyc = cyc;
                end
                if (bus.rx_valid) begin
                    valid_n++;
                    if (exp_q.size() == 0) begin
                        chk("words_pending", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_data", 32'(bus.rx_data), 32'(e));
                        exp_toggle = ~exp_toggle;
                        chk("rx_toggle", 32'(bus.rx_toggle), 32'(exp_toggle));
                    end
                end
            end
        end
    end

    initial begin
        logic [9:0] w;
        bus.serial_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge sclk12);
        chk_idle("reset_state");
        rst = 1'b0;
        repeat (2) @(negedge sclk12);

        // ideal frame, two words
        snap();
        preamble(5, 0, 18);
        send_word(10'h155, 1'b1, 12'h555, 0);
        chk("t1_active_in_frame", 32'(bus.frame_active), 1);
        send_word(10'h2AA, 1'b1, 12'h2AA, 0);
        tail(0);
        chk_counts("t1", 2, 1, 0);
        chk("t1_toggle_end", 32'(bus.rx_toggle), 0);
        chk("t1_active_after", 32'(bus.frame_active), 0);

        // parity error does not abort the frame
        snap();
        preamble(5, 0, 18);
        send_word(10'h001, 1'b0, 12'hC01, 0);
        send_word(10'h155, 1'b1, 12'h155, 0);
        tail(0);
        chk_counts("t2", 2, 1, 0);

        // timing tolerance, +2 and -2
        snap();
        preamble(5, 2, 20);
        send_word(10'h155, 1'b1, 12'h555, 2);
        send_word(10'h2AA, 1'b1, 12'h2AA, 2);
        tail(2);
        chk_counts("t3_plus2", 2, 1, 0);
        snap();
        preamble(5, -2, 16);
        send_word(10'h155, 1'b1, 12'h555, -2);
        send_word(10'h2AA, 1'b1, 12'h2AA, -2);
        tail(-2);
        chk_counts("t3_minus2", 2, 1, 0);

        // data bit 4 mid-bit arrives 3 cycles late
        snap();
        preamble(5, 0, 18);
        w = 10'h155;
        send_bit(1'b1, 0);
        for (int i = 9; i >= 6; i--) send_bit(w[i], 0);
        send_bit(w[5], 3);
        send_bit(w[4], 0);
        hold(1'b0, 40);
        chk_counts("t3_late", 0, 0, 1);
        chk("t3_late_active", 32'(bus.frame_active), 0);

        // quiesce gating
        snap();
        preamble(4, 0, 18);
        hold(1'b1, 6);
        chk("t4_short_quiesce_active", 32'(bus.frame_active), 0);
        hold(1'b0, 30);
        chk_counts("t4_short_quiesce", 0, 0, 0);
        snap();
        preamble(5, 0, 22);
        hold(1'b1, 6);
        chk("t4_long_viol_active", 32'(bus.frame_active), 0);
        hold(1'b0, 30);
        chk_counts("t4_long_viol", 0, 0, 0);

        // line dropout after data bit 5
        snap();
        preamble(5, 0, 18);
        w = 10'h155;
        send_bit(1'b1, 0);
        for (int i = 9; i >= 5; i--) send_bit(w[i], 0);
        hold(1'b0, 40);
        chk_counts("t5_dropout", 0, 0, 1);
        chk("t5_err_timing", err_cyc - mid_cyc, 18);
        chk("t5_active", 32'(bus.frame_active), 0);
        snap();
        preamble(5, 0, 18);
        send_word(10'h2AA, 1'b1, 12'h6AA, 0);
        tail(0);
        chk_counts("t5_recover", 1, 1, 0);

        // reset during data bit 3
        snap();
        preamble(5, 0, 18);
        w = 10'h2AA;
        send_bit(1'b1, 0);
        for (int i = 9; i >= 4; i--) send_bit(w[i], 0);
        bus.serial_in = w[3];
        repeat (2) @(negedge sclk12);
        rst = 1'b1;
        exp_toggle = 1'b0;
        #1;
        chk_idle("t6_async_reset");
        repeat (2) @(negedge sclk12);
        rst = 1'b0;
        hold(1'b0, 40);
        chk_counts("t6_aborted", 0, 0, 0);
        snap();
        preamble(5, 0, 18);
        send_word(10'h155, 1'b1, 12'h555, 0);
        tail(0);
        chk_counts("t6_after_reset", 1, 1, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/coax_biphase_rx.md
Name: coax_biphase_rx

Overview:
Decodes the IBM 3270 coax bi-phase line into 12-bit words. It runs entirely on the sclk12 oversampling clock (12 samples per bit). It sits between the line receiver pin and the word FIFO / bus-clock CDC stage, and is the receive-side counterpart of the transmitter's line encoder. It recovers bit timing from transitions, detects the quiesce and code-violation start sequence, checks parity, and reports framing errors.

Parameters:
HALF_BIT, 6, nominal half-bit time in sclk12 cycles (bit time = 2*HALF_BIT)
TOL, 2, allowed +/- deviation in cycles when classifying a transition
QUIESCE_BITS, 5, minimum consecutive '1' bits required before a code violation is accepted

Ports:
sclk12  input  1  oversampling clock; all logic on its rising edge
rst  input  1  reset, asynchronous, active-high
serial_in  input  1  raw line input, asynchronous to sclk12
rx_data  output  12  {parity_err, first_word, data[9:0]}; held until the next word
rx_valid  output  1  one-cycle pulse when rx_data updates
rx_toggle  output  1  inverts on every rx_valid, for bus-clock CDC
frame_active  output  1  high from code violation accepted to end of frame/error
frame_end  output  1  one-cycle pulse on a clean end of frame
frame_err  output  1  one-cycle pulse on any framing/timing error inside a frame

Behaviour:
- Encoding: '1' = high half then low half (mid-bit falling edge); '0' = low then high (mid-bit rising edge). Idle line is low.
- Input path: 2-FF synchronizer, then one edge-detect register. Line delay to the decoder is 3 cycles, which is not otherwise visible.
- cnt: 6-bit cycles-since-reference counter. It saturates at 63 and resets on every transition in HUNT/VIOL states, and on each mid-bit transition in bit states.
- Run classes in HUNT/VIOL: S = HALF_BIT±TOL; L = 2*HALF_BIT±TOL; V = 3*HALF_BIT±TOL; anything else = X.
- States:
  - HUNT: counts consecutive S runs (qcount, saturating). An L or X run clears qcount. A rising edge ending a low S run with qcount >= 2*QUIESCE_BITS-1 goes to VIOL_HI.
  - VIOL_HI: the next falling edge must end a V run, then go to VIOL_LO. Any other run goes to HUNT with qcount=0, with no error pulse.
  - VIOL_LO: a rising edge ending a V run goes to SYNC, loads cnt=HALF_BIT, and sets frame_active=1 and first_word=1. Any other run goes to HUNT.
  - SYNC / DATA / PARITY are bit states. A transition with cnt in 2*HALF_BIT±TOL is a mid-bit transition: decode the bit and reset cnt to 0. A transition with cnt in HALF_BIT±TOL is a boundary transition and is ignored. Any other transition, or cnt reaching 2*HALF_BIT+TOL+1 with no mid-bit transition, raises frame_err, clears frame_active, and returns to HUNT.
  - SYNC: bit '1' goes to DATA with bit index 9. Bit '0' raises frame_end, clears frame_active, and returns to HUNT.
  - DATA: shifts in MSB first (data[9] first) and goes to PARITY after data[0].
  - PARITY: parity_err = parity bit XOR (^data). Even parity holds over 10 data bits + parity. The cycle after the parity mid-bit, rx_data updates, rx_valid pulses, rx_toggle inverts, and first_word clears. Then go to SYNC.
- Latency: rx_valid asserts exactly 1 cycle after the sclk12 edge on which the parity mid-bit transition is detected.
- A parity error does not abort the frame; the word is delivered with bit 11 set.
- Pulses are mutually exclusive per cycle. frame_end / frame_err never coincide with rx_valid.
- Reset (any time, including mid-frame) takes effect immediately, with no partial word emitted. Reset values: state=HUNT, rx_data=0, rx_valid=0, rx_toggle=0, frame_active=0, frame_end=0, frame_err=0, cnt=0, qcount=0, synchronizer=0.

Test Plan:
1. Ideal frame: 5x'1', violation (18 high / 18 low), words 0x155 and 0x2AA with correct parity, then sync '0' -> two rx_valid; rx_data=0x555 (first_word=1) then 0x2AA; rx_toggle ends at 0; one frame_end; frame_err never.
2. Parity: word 0x001 sent with parity bit 0 -> rx_data=0xC01 on a first word; the frame continues and the next good word is delivered with bit 11=0.
3. Timing tolerance: the same frame with every run stretched +2 and then shrunk -2 cycles -> identical output. With +3 on one data mid-bit -> frame_err, frame_active=0, no rx_valid for that word.
4. Quiesce gating: only 4x'1' before a valid violation -> no frame_active, no outputs. A violation high run of 22 cycles -> stays HUNT, no frame_err.
5. Line dropout: line held low for 40 cycles after data bit 5 -> frame_err pulse exactly at cnt=15 after the last mid-bit; a following good frame decodes normally.
6. Reset mid-word: rst asserted during DATA bit 3 for 2 cycles -> all outputs 0 asynchronously, no rx_valid. The next complete frame decodes with first_word=1.
